// File: rtl/axis_stream_fifo.sv
// AXI4-Stream FIFO with sideband fields, output register and optional
// store-and-forward frame mode with overflow and bad-frame dropping.
module axis_stream_fifo #(
  parameter int DEPTH          = 4096,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter int LAST_ENABLE    = 1,
  parameter int ID_ENABLE      = 0,
  parameter int ID_WIDTH       = 8,
  parameter int DEST_ENABLE    = 0,
  parameter int DEST_WIDTH     = 8,
  parameter int USER_ENABLE    = 1,
  parameter int USER_WIDTH     = 1,
  parameter int FRAME_FIFO     = 0,
  parameter int DROP_BAD_FRAME = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int WORDS  = (KEEP_ENABLE != 0) ? DEPTH / KEEP_WIDTH : DEPTH;
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int W      = DATA_WIDTH + KEEP_WIDTH + 1
                        + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [W-1:0] OUT_RST = {
    {DATA_WIDTH{1'b0}}, {KEEP_WIDTH{1'b1}}, 1'b1,
    {ID_WIDTH{1'b0}}, {DEST_WIDTH{1'b0}}, {USER_WIDTH{1'b0}}
  };

  typedef enum logic {
    ST_PASS,
    ST_DROP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] wr_commit_q, wr_commit_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wr_vis;

  logic [W-1:0] mem [WORDS];
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] wdata;

  logic m_valid_q, m_valid_d;
  logic ovf_q, ovf_d;
  logic bad_q, bad_d;
  logic good_q, good_d;

  logic full, empty, open_frame;
  logic push, pop, mem_we;

  logic [KEEP_WIDTH-1:0] keep_in;
  logic                  last_in;
  logic [ID_WIDTH-1:0]   id_in;
  logic [DEST_WIDTH-1:0] dest_in;
  logic [USER_WIDTH-1:0] user_in;

  // Disabled fields are stored as their fixed output values.
  assign keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign last_in = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
  assign id_in   = (ID_ENABLE != 0) ? s_axis_tid : '0;
  assign dest_in = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
  assign user_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;

  assign wdata = {s_axis_tdata, keep_in, last_in, id_in, dest_in, user_in};

  assign full = (wr_ptr_q ==
                 {~rd_ptr_q[ADDR_W], rd_ptr_q[ADDR_W-1:0]});

  // Frame mode only exposes beats of completed frames.
  assign wr_vis     = (FRAME_FIFO != 0) ? wr_commit_q : wr_ptr_q;
  assign empty      = (rd_ptr_q == wr_vis);
  assign open_frame = (wr_ptr_q != wr_commit_q);

  always_comb begin
    s_axis_tready = !full;
    if (FRAME_FIFO != 0) begin
      s_axis_tready = !full || open_frame || (state_q == ST_DROP);
    end
  end

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = !empty && (!m_valid_q || m_axis_tready);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    state_d     = state_q;
    mem_we      = 1'b0;
    ovf_d       = 1'b0;
    bad_d       = 1'b0;
    good_d      = 1'b0;
    if (push) begin
      if (FRAME_FIFO == 0) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        good_d   = last_in;
      end else if (state_q == ST_DROP || full) begin
        wr_ptr_d = wr_commit_q;
        ovf_d    = (state_q == ST_PASS);
        state_d  = last_in ? ST_PASS : ST_DROP;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (last_in) begin
          if (DROP_BAD_FRAME != 0 && user_in[0]) begin
            wr_ptr_d = wr_commit_q;
            bad_d    = 1'b1;
          end else begin
            wr_commit_d = wr_ptr_q + PTR_ONE;
            good_d      = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    out_d     = out_q;
    m_valid_d = m_valid_q;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      out_d     = mem[rd_ptr_q[ADDR_W-1:0]];
      m_valid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PASS;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      out_q       <= OUT_RST;
      m_valid_q   <= 1'b0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      good_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      out_q       <= out_d;
      m_valid_q   <= m_valid_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
    end
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
          m_axis_tid, m_axis_tdest, m_axis_tuser} = out_q;

  assign m_axis_tvalid     = m_valid_q;
  assign status_overflow   = ovf_q;
  assign status_bad_frame  = bad_q;
  assign status_good_frame = good_q;

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Bench for axis_stream_fifo: a streaming instance and a frame-mode
// instance share stimulus; a queue model predicts every handshake.
module tb_axis_stream_fifo;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int WORDS = 1024;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [0:0]    s_user = '0;
  logic [7:0]    s_id = '0;
  logic [7:0]    s_dest = '0;
  logic          m_ready = 1'b0;

  logic          n_s_ready, f_s_ready;
  logic [DW-1:0] n_m_data, f_m_data;
  logic [KW-1:0] n_m_keep, f_m_keep;
  logic          n_m_valid, f_m_valid;
  logic          n_m_last, f_m_last;
  logic [7:0]    n_m_id, f_m_id, n_m_dest, f_m_dest;
  logic [0:0]    n_m_user, f_m_user;
  logic          n_ovf, f_ovf, n_bad, f_bad, n_good, f_good;

  always #5 clk = ~clk;

  axis_stream_fifo #(
    .DEPTH(65536), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid), .s_axis_tready(n_s_ready),
    .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
    .m_axis_tdata(n_m_data), .m_axis_tkeep(n_m_keep),
    .m_axis_tvalid(n_m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(n_m_last), .m_axis_tid(n_m_id),
    .m_axis_tdest(n_m_dest), .m_axis_tuser(n_m_user),
    .status_overflow(n_ovf), .status_bad_frame(n_bad),
    .status_good_frame(n_good)
  );

  axis_stream_fifo #(
    .DEPTH(65536), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .FRAME_FIFO(1), .DROP_BAD_FRAME(1)
  ) dut_frame (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid), .s_axis_tready(f_s_ready),
    .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
    .m_axis_tdata(f_m_data), .m_axis_tkeep(f_m_keep),
    .m_axis_tvalid(f_m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(f_m_last), .m_axis_tid(f_m_id),
    .m_axis_tdest(f_m_dest), .m_axis_tuser(f_m_user),
    .status_overflow(f_ovf), .status_bad_frame(f_bad),
    .status_good_frame(f_good)
  );

  logic          o_s_ready, o_m_valid, o_m_last;
  logic [DW-1:0] o_m_data;
  logic [KW-1:0] o_m_keep;
  logic          o_m_user, o_ovf, o_bad, o_good;

  assign o_s_ready = sel ? f_s_ready : n_s_ready;
  assign o_m_valid = sel ? f_m_valid : n_m_valid;
  assign o_m_data  = sel ? f_m_data : n_m_data;
  assign o_m_keep  = sel ? f_m_keep : n_m_keep;
  assign o_m_last  = sel ? f_m_last : n_m_last;
  assign o_m_user  = sel ? f_m_user[0] : n_m_user[0];
  assign o_ovf     = sel ? f_ovf : n_ovf;
  assign o_bad     = sel ? f_bad : n_bad;
  assign o_good    = sel ? f_good : n_good;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  beat_t ram_q[$];
  beat_t pend_q[$];
  beat_t out_b;
  logic  have_out = 1'b0;
  logic  drop = 1'b0;
  logic  exp_ovf = 1'b0, exp_bad = 1'b0, exp_good = 1'b0;
  logic  last_acc = 1'b0;
  logic  toggle_rdy = 1'b0;
  int    out_cnt = 0;
  int    ovf_seen = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic  rdy, mfire, popm, pushm, fullm;
    beat_t b;
    fullm = (ram_q.size() + pend_q.size()) >= WORDS;
    if (sel) rdy = !fullm || drop || (pend_q.size() != 0);
    else     rdy = ram_q.size() < WORDS;
    chk("s_tready", DW'(o_s_ready), DW'(rdy));
    chk("m_tvalid", DW'(o_m_valid), DW'(have_out));
    if (have_out) begin
      chk("m_tdata", o_m_data, out_b.d);
      chk("m_tkeep", DW'(o_m_keep), DW'(out_b.k));
      chk("m_tlast", DW'(o_m_last), DW'(out_b.l));
      chk("m_tuser", DW'(o_m_user), DW'(out_b.u));
    end
    chk("st_good", DW'(o_good), DW'(exp_good));
    chk("st_ovf", DW'(o_ovf), DW'(exp_ovf));
    chk("st_bad", DW'(o_bad), DW'(exp_bad));
    if (o_ovf) ovf_seen++;
    exp_good = 1'b0;
    exp_ovf  = 1'b0;
    exp_bad  = 1'b0;
    mfire = have_out && m_ready;
    popm  = (ram_q.size() != 0) && (!have_out || m_ready);
    pushm = s_valid && rdy;
    last_acc = pushm;
    if (mfire) begin
      have_out = 1'b0;
      out_cnt++;
    end
    if (popm) begin
      out_b = ram_q.pop_front();
      have_out = 1'b1;
    end
    if (pushm) begin
      b.d = s_data; b.k = s_keep; b.l = s_last; b.u = s_user[0];
      if (!sel) begin
        ram_q.push_back(b);
        exp_good = s_last;
      end else if (drop || fullm) begin
        pend_q.delete();
        exp_ovf = !drop;
        drop = !s_last;
      end else begin
        pend_q.push_back(b);
        if (s_last && s_user[0]) begin
          pend_q.delete();
          exp_bad = 1'b1;
        end else if (s_last) begin
          foreach (pend_q[i]) ram_q.push_back(pend_q[i]);
          pend_q.delete();
          exp_good = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (toggle_rdy) m_ready = !m_ready;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ram_q.delete();
    pend_q.delete();
    have_out = 1'b0;
    drop = 1'b0;
    exp_ovf = 1'b0;
    exp_bad = 1'b0;
    exp_good = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic l,
                      input logic u);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    s_user = u;
    last_acc = 1'b0;
    for (int n = 0; n < 4000 && !last_acc; n++) step();
    chk("send_accepted", DW'(last_acc), DW'(1'b1));
    s_valid = 1'b0;
    s_last = 1'b0;
    s_user = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int base;
    int acc_cnt;
    do_reset();
    chk("rst_m_tvalid", DW'(o_m_valid), DW'(1'b0));
    chk("rst_s_tready", DW'(o_s_ready), DW'(1'b1));

    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(rnd_data(), i == 9, 1'b0);
    idle(3);
    do_reset();
    m_ready = 1'b1;
    base = out_cnt;
    idle(20);
    chk("no_stale_beat", DW'(out_cnt - base), DW'(0));

    base = out_cnt;
    for (int i = 1; i <= 4; i++) send(DW'(i), i == 4, 1'b0);
    idle(8);
    chk("pkt4_count", DW'(out_cnt - base), DW'(4));

    m_ready = 1'b0;
    s_valid = 1'b1;
    s_last = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      s_data = rnd_data();
      step();
      if (last_acc) acc_cnt++;
    end
    // RAM holds WORDS beats and the output register one more
    chk("fill_count", DW'(acc_cnt), DW'(WORDS + 1));
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    idle(2);
    chk("ready_after_pop", DW'(o_s_ready), DW'(1'b1));
    m_ready = 1'b1;
    idle(WORDS + 8);
    chk("drained", DW'(o_m_valid), DW'(1'b0));

    base = out_cnt;
    m_ready = 1'b1;
    toggle_rdy = 1'b1;
    for (int p = 0; p < 500; p++)
      for (int b = 0; b < 4; b++) send(rnd_data(), b == 3, 1'b0);
    idle(WORDS * 2 + 16);
    toggle_rdy = 1'b0;
    m_ready = 1'b1;
    idle(4);
    chk("stream_count", DW'(out_cnt - base), DW'(2000));
    chk("stream_model_empty", DW'(ram_q.size()), DW'(0));

    sel = 1'b1;
    do_reset();
    m_ready = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 3; i++) send(rnd_data(), 1'b0, 1'b0);
    idle(10);
    chk("frame_held", DW'(o_m_valid), DW'(1'b0));
    send(rnd_data(), 1'b1, 1'b0);
    idle(10);
    chk("frame_count", DW'(out_cnt - base), DW'(4));

    base = out_cnt;
    ovf_seen = 0;
    for (int i = 0; i < 1100; i++) send(rnd_data(), i == 1099, 1'b0);
    idle(4);
    chk("ovf_pulses", DW'(ovf_seen), DW'(1));
    chk("ovf_dropped", DW'(out_cnt - base), DW'(0));
    for (int i = 0; i < 4; i++) send(rnd_data(), i == 3, 1'b0);
    idle(10);
    chk("after_ovf_count", DW'(out_cnt - base), DW'(4));

    base = out_cnt;
    send(rnd_data(), 1'b0, 1'b0);
    send(rnd_data(), 1'b1, 1'b1);
    idle(6);
    chk("bad_dropped", DW'(out_cnt - base), DW'(0));
    send(rnd_data(), 1'b0, 1'b1);
    send(rnd_data(), 1'b1, 1'b0);
    idle(6);
    chk("good_after_bad", DW'(out_cnt - base), DW'(2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
